xlr8_result_drain: RTL and testbench

XLR8_RESULT_DRAIN -- requirements
Module: xlr8_result_drain

---
 rtl/xlr8_result_drain.sv | 185 ++++++++++++++++++
 tb/tb_xlr8_result_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_result_drain.sv
// Streams a captured DIM x DIM result matrix out over a valid/ready port, row-major.
// Define XLR8_DRAIN_ROWSUM_EN to append a wrapping row-sum word after every row.
module xlr8_result_drain #(
  parameter int DIM = 8,
  parameter int DW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  done,
  input  logic [DIM*DIM*DW-1:0] c_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic [1:0]            dbg_state
);

  // Handshake: a word transfers on any rising edge where out_valid & out_ready;
  // while out_valid=1 and out_ready=0, out_data/out_last are held unchanged.

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int EW = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef XLR8_DRAIN_ROWSUM_EN
    ST_DRAIN = 2'd1,
    ST_SUM   = 2'd2
`else
    ST_DRAIN = 2'd1
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic                    done_q;
  logic                    armed_q;
  logic [DIM*DIM*DW-1:0]   shadow_q, shadow_d;
  logic [IW-1:0]           row_q, row_d;
  logic [IW-1:0]           col_q, col_d;
  logic                    overrun_q, overrun_d;
  logic                    done_edge;
  logic                    drop;
  logic                    hs;
  logic [EW-1:0]           elem_idx;
  logic [DW-1:0]           elem;
`ifdef XLR8_DRAIN_ROWSUM_EN
  logic [DW-1:0]           sum_q, sum_d;
`endif

  // armed_q masks the first clock after reset so a done already high at
  // release only primes done_q instead of looking like a fresh edge.
  assign done_edge = done & ~done_q & armed_q;
  assign drop      = done_edge & (state_q != ST_IDLE);
  assign hs        = out_valid & out_ready;
  assign elem_idx  = EW'(row_q) * EW'(DIM) + EW'(col_q);
  assign elem      = shadow_q[elem_idx*DW +: DW];

  assign out_valid = (state_q != ST_IDLE);
  assign busy      = out_valid;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        out_data = elem;
`ifdef XLR8_DRAIN_ROWSUM_EN
        out_last = 1'b0;
`else
        out_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
`endif
      end
`ifdef XLR8_DRAIN_ROWSUM_EN
      ST_SUM: begin
        out_data = sum_q;
        out_last = (row_q == LAST_IDX);
      end
`endif
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q;
`ifdef XLR8_DRAIN_ROWSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (done_edge) begin
          shadow_d = c_flat;
          row_d    = '0;
          col_d    = '0;
          state_d  = ST_DRAIN;
`ifdef XLR8_DRAIN_ROWSUM_EN
          sum_d    = '0;
`endif
        end
      end
      ST_DRAIN: begin
        if (hs) begin
`ifdef XLR8_DRAIN_ROWSUM_EN
          sum_d = sum_q + elem;
`endif
          if (col_q == LAST_IDX) begin
            col_d = '0;
`ifdef XLR8_DRAIN_ROWSUM_EN
            state_d = ST_SUM;
`else
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              state_d = ST_IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
`endif
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
`ifdef XLR8_DRAIN_ROWSUM_EN
      ST_SUM: begin
        if (hs) begin
          sum_d = '0;
          if (row_q == LAST_IDX) begin
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // A dropped edge beats a simultaneous clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      shadow_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
`ifdef XLR8_DRAIN_ROWSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done;
      armed_q   <= 1'b1;
      shadow_q  <= shadow_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
`ifdef XLR8_DRAIN_ROWSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_xlr8_result_drain.sv
// Directed bench for xlr8_result_drain: expected-word queue scoreboard, monitor on the falling edge.
module tb_xlr8_result_drain;

  localparam int DIM = 8;
  localparam int DW  = 16;
`ifdef XLR8_DRAIN_ROWSUM_EN
  localparam int FRAME = DIM * (DIM + 1);
`else
  localparam int FRAME = DIM * DIM;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  done;
  logic [DIM*DIM*DW-1:0] c_flat;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  out_last;
  logic                  busy;
  logic                  overrun;
  logic                  clr_overrun;
  logic [1:0]            dbg_state;

  always #5 clk = ~clk;

  xlr8_result_drain #(.DIM(DIM), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .c_flat(c_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .overrun(overrun),
    .clr_overrun(clr_overrun), .dbg_state(dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW:0] exp_q[$];
  logic [DW-1:0] c_mat[DIM][DIM];
  int popped   = 0;
  int busy_cnt = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;
  logic [DW:0]   mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: Cij=i*8+j, mode 1: all F000, mode 2: AAAA ^ (i*8+j)
  task automatic set_matrix(input int mode);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        case (mode)
          0:       c_mat[i][j] = 16'(i * 8 + j);
          1:       c_mat[i][j] = 16'hF000;
          default: c_mat[i][j] = 16'hAAAA ^ 16'(i * 8 + j);
        endcase
        c_flat[(i*DIM+j)*DW +: DW] = c_mat[i][j];
      end
    end
  endtask

  task automatic push_frame();
    logic [DW-1:0] s;
    logic          lst;
    for (int i = 0; i < DIM; i++) begin
      s = '0;
      for (int j = 0; j < DIM; j++) begin
        s = s + c_mat[i][j];
`ifdef XLR8_DRAIN_ROWSUM_EN
        lst = 1'b0;
`else
        lst = (i == DIM - 1) && (j == DIM - 1);
`endif
        exp_q.push_back({lst, c_mat[i][j]});
      end
`ifdef XLR8_DRAIN_ROWSUM_EN
      exp_q.push_back({(i == DIM - 1), s});
`endif
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic wait_popped(input int n, input int budget);
    int k = 0;
    while (popped < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (popped < n) check("wait_popped_timeout", popped, n);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      check("busy_eq_valid", busy, out_valid);
      if (busy) busy_cnt++;
      if (!out_valid) check("last_when_idle", out_last, 0);
      if (hold_pend) begin
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", out_data, mon_e[DW-1:0]);
          check("word_last", out_last, mon_e[DW]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; done = 1'b1; out_ready = 1'b1; clr_overrun = 1'b0; c_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_state", dbg_state, 0);

    // release with done already high: no capture
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_capture_on_release", out_valid, 0);
    done = 1'b0;
    repeat (2) @(posedge clk);

    // basic frame, ready held high
    set_matrix(0); push_frame(); busy_cnt = 0; popped = 0;
    pulse_done();
    check("latency1_valid", out_valid, 1);
    check("latency1_data", out_data, 0);
    wait_drain(200);
    check("frame_busy_cycles", busy_cnt, FRAME);
    check("frame_words", popped, FRAME);
    check("frame_end_idle", out_valid, 0);

    // ready toggling; first valid cycle sees ready=0
    set_matrix(0); push_frame(); busy_cnt = 0; popped = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("toggle_drain", exp_q.size(), 0);
    check("toggle_busy_cycles", busy_cnt, 2 * FRAME);

    // overrun mid-frame, set-wins, clear, drop on the final handshake
    set_matrix(0); push_frame(); popped = 0;
    pulse_done();
    wait_popped(11, 100);
    set_matrix(2);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    check("overrun_set", overrun, 1);
    check("overrun_still_busy", out_valid, 1);
    wait_popped(31, 100);
    done = 1'b1; clr_overrun = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; clr_overrun = 1'b0;
    check("overrun_set_wins", overrun, 1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    check("overrun_cleared", overrun, 0);
    wait_popped(FRAME, 100);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    check("drop_on_last_overrun", overrun, 1);
    check("drop_on_last_idle", out_valid, 0);
    repeat (5) @(negedge clk);
    #1;
    check("no_back_to_back", out_valid, 0);
    check("overrun_frame_drain", exp_q.size(), 0);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    check("overrun_clear2", overrun, 0);

    // reset mid-frame, then restart from C00
    set_matrix(0); push_frame(); popped = 0;
    pulse_done();
    wait_popped(21, 100);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", out_data, 0);
    check("abort_last", out_last, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_words", out_valid, 0);
    popped = 0; push_frame();
    pulse_done();
    check("restart_c00", out_data, 0);
    wait_drain(200);
    check("restart_words", popped, FRAME);

    // done held high for 200 cycles: single frame
    set_matrix(2); push_frame(); popped = 0;
    @(posedge clk); #1;
    done = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("held_done_words", popped, FRAME);
    check("held_done_drain", exp_q.size(), 0);
    check("held_done_overrun", overrun, 0);

`ifdef XLR8_DRAIN_ROWSUM_EN
    set_matrix(1); push_frame(); popped = 0;
    pulse_done();
    wait_drain(300);
    check("rowsum_words", popped, 72);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
